demux1to16_reg: RTL and testbench

Registered 1-to-16 write distributor: the write-side counterpart of the CPU's 16-input `mux16to1` read select. It accepts one N-bit word per valid/ready handshake and stores it into one of sixteen output registers `out0..out15` chosen by `fn_sel`. A broadcast mode sweeps the same word into all sixteen registers, one per cycle. It sits in the datapath where results are written back into the register bank that `mux16to1` later reads.

---
 rtl/demux1to16_reg_pkg.sv | 9 +
 rtl/demux1to16_reg_if.sv | 29 ++
 rtl/demux1to16_reg_decoder4to16.sv | 9 +
 rtl/demux1to16_reg.sv | 105 ++++++++++
 tb/tb_demux1to16_reg.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/demux1to16_reg_pkg.sv
// Shared constants and FSM state type for the registered 1-to-16 write distributor.
package demux_pkg;
    localparam int DEF_N     = 16;
    localparam int SEL_W     = 5;
    localparam int BCAST_BIT = 4;
    localparam int NUM_OUT   = 16;

    typedef enum logic {IDLE, SWEEP} state_t;
endpackage

// File: rtl/demux1to16_reg_if.sv
// Write-request handshake plus the sixteen stored registers and write strobes.
interface demux1to16_reg_if
    import demux_pkg::*;
#(
    parameter int N = DEF_N
);
    logic [N-1:0]       in;
    logic [SEL_W-1:0]   fn_sel;
    logic               valid;
    logic               ready;
    logic [NUM_OUT-1:0] wr_en;
    logic               busy;
    logic [N-1:0]       out0, out1, out2, out3, out4, out5, out6, out7;
    logic [N-1:0]       out8, out9, out10, out11, out12, out13, out14, out15;

    modport master (
        output in, fn_sel, valid,
        input  ready, wr_en, busy,
        input  out0, out1, out2, out3, out4, out5, out6, out7,
        input  out8, out9, out10, out11, out12, out13, out14, out15
    );

    modport slave (
        input  in, fn_sel, valid,
        output ready, wr_en, busy,
        output out0, out1, out2, out3, out4, out5, out6, out7,
        output out8, out9, out10, out11, out12, out13, out14, out15
    );
endinterface

// File: rtl/demux1to16_reg_decoder4to16.sv
// 4-bit index to 16-bit one-hot; shared by register enables and the wr_en strobe.
module decoder4to16
    import demux_pkg::*;
(
    input  logic [3:0]         i_idx,
    output logic [NUM_OUT-1:0] o_onehot
);
    assign o_onehot = NUM_OUT'(1) << i_idx;
endmodule

// File: rtl/demux1to16_reg.sv
// Registered 1-to-16 write distributor with a 16-cycle broadcast sweep.
module demux1to16_reg
    import demux_pkg::*;
#(
    parameter int N = DEF_N
)(
    input  logic               clk,
    input  logic               rst_n,
    demux1to16_reg_if.slave    bus
);
    state_t             r_state, w_state_nxt;
    logic [N-1:0]       r_out [NUM_OUT];
    logic [N-1:0]       r_bdata, w_bdata_nxt;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic [NUM_OUT-1:0] r_wr_en;
    logic [NUM_OUT-1:0] w_we, w_onehot;
    logic [3:0]         w_dec_idx;
    logic [N-1:0]       w_wdata;

    // During a sweep the decoder follows the sweep pointer, otherwise the request.
    assign w_dec_idx = (r_state == SWEEP) ? r_idx : bus.fn_sel[3:0];
    assign w_wdata   = (r_state == SWEEP) ? r_bdata : bus.in;

    decoder4to16 u_dec (
        .i_idx    (w_dec_idx),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bdata_nxt = r_bdata;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_we        = '0;
        case (r_state)
            IDLE: begin
                if (bus.valid) begin
                    if (bus.fn_sel[BCAST_BIT]) begin
                        w_bdata_nxt = bus.in;
                        w_idx_nxt   = bus.fn_sel[3:0];
                        w_cnt_nxt   = 4'd0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = SWEEP;
                    end else begin
                        w_we = w_onehot;
                    end
                end
            end
            SWEEP: begin
                w_we      = w_onehot;
                w_idx_nxt = r_idx + 4'd1;
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bdata <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_wr_en <= '0;
            for (int k = 0; k < NUM_OUT; k++) r_out[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bdata <= w_bdata_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_wr_en <= w_we;
            for (int k = 0; k < NUM_OUT; k++)
                if (w_we[k]) r_out[k] <= w_wdata;
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.busy  = r_busy;
    assign bus.wr_en = r_wr_en;
    assign bus.out0  = r_out[0];
    assign bus.out1  = r_out[1];
    assign bus.out2  = r_out[2];
    assign bus.out3  = r_out[3];
    assign bus.out4  = r_out[4];
    assign bus.out5  = r_out[5];
    assign bus.out6  = r_out[6];
    assign bus.out7  = r_out[7];
    assign bus.out8  = r_out[8];
    assign bus.out9  = r_out[9];
    assign bus.out10 = r_out[10];
    assign bus.out11 = r_out[11];
    assign bus.out12 = r_out[12];
    assign bus.out13 = r_out[13];
    assign bus.out14 = r_out[14];
    assign bus.out15 = r_out[15];
endmodule

// File: tb/tb_demux1to16_reg.sv
// Directed bench for demux1to16_reg: vector table for single writes, hand sequences for sweeps.
module tb_demux1to16_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    demux1to16_reg_if #(.N(16)) bus ();

    demux1to16_reg #(.N(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] w_outs [16];
    assign w_outs[0]  = bus.out0;
    assign w_outs[1]  = bus.out1;
    assign w_outs[2]  = bus.out2;
    assign w_outs[3]  = bus.out3;
    assign w_outs[4]  = bus.out4;
    assign w_outs[5]  = bus.out5;
    assign w_outs[6]  = bus.out6;
    assign w_outs[7]  = bus.out7;
    assign w_outs[8]  = bus.out8;
    assign w_outs[9]  = bus.out9;
    assign w_outs[10] = bus.out10;
    assign w_outs[11] = bus.out11;
    assign w_outs[12] = bus.out12;
    assign w_outs[13] = bus.out13;
    assign w_outs[14] = bus.out14;
    assign w_outs[15] = bus.out15;

    logic [15:0] m_out [16];

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] din;
        logic        vld;
        logic [15:0] exp_wr;
        int          exp_idx;   // -1: nothing written
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s out%0d", name, k), 32'(w_outs[k]), 32'(m_out[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] sel, input logic [15:0] din, input logic vld);
        bus.fn_sel = sel;
        bus.in     = din;
        bus.valid  = vld;
    endtask

    initial begin
        logic [15:0] bval;
        int          idx;

        vecs[0] = '{5'd3,  16'h1234, 1'b1, 16'h0008, 3};
        vecs[1] = '{5'd15, 16'hBEEF, 1'b1, 16'h8000, 15};
        vecs[2] = '{5'd0,  16'hFFFF, 1'b0, 16'h0000, -1};
        vecs[3] = '{5'd7,  16'hC001, 1'b1, 16'h0080, 7};
        vecs[4] = '{5'd3,  16'h5555, 1'b1, 16'h0008, 3};
        vecs[5] = '{5'd9,  16'h9999, 1'b0, 16'h0000, -1};

        for (int k = 0; k < 16; k++) m_out[k] = 16'h0;

        // reset with garbage on the inputs
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(5'($urandom), 16'($urandom), 1'($urandom));
            tick();
        end
        chk_all("reset");
        chk("reset wr_en", 32'(bus.wr_en), 32'h0);
        chk("reset ready", 32'(bus.ready), 32'h1);
        chk("reset busy",  32'(bus.busy),  32'h0);
        drive(5'd0, 16'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // back-to-back single writes from the table
        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].sel, vecs[v].din, vecs[v].vld);
            tick();
            if (vecs[v].exp_idx >= 0) m_out[vecs[v].exp_idx] = vecs[v].din;
            chk($sformatf("vec%0d wr_en", v), 32'(bus.wr_en), 32'(vecs[v].exp_wr));
            chk($sformatf("vec%0d ready", v), 32'(bus.ready), 32'h1);
            chk($sformatf("vec%0d busy", v),  32'(bus.busy),  32'h0);
            chk_all($sformatf("vec%0d", v));
        end

        // broadcast from index 14, with a competing single write held during the sweep
        drive(5'b1_1110, 16'h00A5, 1'b1);
        tick();
        chk("bc accept ready", 32'(bus.ready), 32'h0);
        chk("bc accept busy",  32'(bus.busy),  32'h1);
        chk("bc accept wr_en", 32'(bus.wr_en), 32'h0);
        chk_all("bc accept");
        drive(5'd2, 16'h7777, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            idx = (14 + i) % 16;
            m_out[idx] = 16'h00A5;
            chk($sformatf("bc%0d wr_en", i), 32'(bus.wr_en), 32'(16'h1 << idx));
            chk($sformatf("bc%0d ready", i), 32'(bus.ready), (i == 15) ? 32'h1 : 32'h0);
            chk($sformatf("bc%0d busy", i),  32'(bus.busy),  (i == 15) ? 32'h0 : 32'h1);
            chk_all($sformatf("bc%0d", i));
        end
        tick();
        m_out[2] = 16'h7777;
        chk("held req wr_en", 32'(bus.wr_en), 32'h0004);
        chk_all("held req");
        drive(5'd0, 16'h0, 1'b0);
        tick();
        chk("post idle wr_en", 32'(bus.wr_en), 32'h0);

        // reset in the middle of a sweep from index 0
        bval = 16'h3C3C;
        drive(5'b1_0000, bval, 1'b1);
        tick();
        drive(5'd0, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("mid sweep out5", 32'(bus.out5), 32'(bval));
        chk("mid sweep out6", 32'(bus.out6), 32'(m_out[6]));
        chk("mid sweep busy", 32'(bus.busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) m_out[k] = 16'h0;
        chk_all("async rst");
        chk("async rst wr_en", 32'(bus.wr_en), 32'h0);
        chk("async rst busy",  32'(bus.busy),  32'h0);
        chk("async rst ready", 32'(bus.ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("after rst%0d wr_en", i), 32'(bus.wr_en), 32'h0);
            chk($sformatf("after rst%0d busy", i),  32'(bus.busy),  32'h0);
        end
        chk_all("after rst");

        // fill every index, then read back through a 16:1 select
        for (int k = 0; k < 16; k++) begin
            drive(5'(k), 16'hA000 + 16'(k * 16'h0111), 1'b1);
            tick();
            chk($sformatf("fill%0d wr_en", k), 32'(bus.wr_en), 32'(16'h1 << k));
        end
        drive(5'd0, 16'h0, 1'b0);
        tick();
        for (int s = 0; s < 16; s++)
            chk($sformatf("mux sel%0d", s), 32'(w_outs[s]), 32'(16'hA000 + 16'(s * 16'h0111)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
